// File: rtl/ex_pipe_if.sv
// Handshake and operand bundle between the venus decode/register-read stage,
// the execute stage, and the memory/write-back stage.
interface ex_pipe_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 4
);
  logic               v_i;
  logic               stall_o;
  logic [XLEN-1:0]    rd_value_i;
  logic [XLEN-1:0]    rs_value_i;
  logic [XLEN-1:0]    imm_value_i;
  logic [RADDR_W-1:0] rd_addr_i;
  logic [6:0]         opcode_i;
  logic               ctrl_inte_i;
  logic               ctrl_logic_i;
  logic               ctrl_shift_i;
  logic               ctrl_ld_i;
  logic               ctrl_st_i;
  logic               ctrl_br_i;
  logic               immf_i;
  logic               v_o;
  logic               stall_i;
  logic [XLEN-1:0]    result_o;
  logic [RADDR_W-1:0] rd_addr_o;
  logic               wb_en_o;
  logic               branch_en_o;
  logic [5:0]         flags_o;

  modport master (
    output v_i, rd_value_i, rs_value_i, imm_value_i, rd_addr_i, opcode_i,
    output ctrl_inte_i, ctrl_logic_i, ctrl_shift_i, ctrl_ld_i, ctrl_st_i, ctrl_br_i,
    output immf_i, stall_i,
    input  stall_o, v_o, result_o, rd_addr_o, wb_en_o, branch_en_o, flags_o
  );

  modport slave (
    input  v_i, rd_value_i, rs_value_i, imm_value_i, rd_addr_i, opcode_i,
    input  ctrl_inte_i, ctrl_logic_i, ctrl_shift_i, ctrl_ld_i, ctrl_st_i, ctrl_br_i,
    input  immf_i, stall_i,
    output stall_o, v_o, result_o, rd_addr_o, wb_en_o, branch_en_o, flags_o
  );
endinterface

// File: rtl/ex_pipe.sv
// venus execute stage: add/sub, logic, iterative shifter, ld/st address and
// branch evaluation against a registered condition-flag register.
module ex_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADDR_W    = 4,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic     clk,
  input  logic     rst,
  ex_pipe_if.slave bus
);
  localparam int unsigned SW   = $clog2(XLEN);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA, SH_ROL} shmode_t;

  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] x,
                                                input shmode_t mode,
                                                input logic [SW:0] amt);
    logic [XLEN-1:0] r;
    case (mode)
      SH_SLL:  r = x << amt;
      SH_SRL:  r = x >> amt;
      SH_SRA:  r = $signed(x) >>> amt;
      default: r = (x << amt) | (x >> (XLEN - 32'(amt)));
    endcase
    return r;
  endfunction

  function automatic logic [5:0] mk_flags(input logic [XLEN-1:0] r,
                                          input logic cy, input logic ov);
    logic z, n;
    z = (r == '0);
    n = r[XLEN-1];
    return {z, !z && !n, n, cy, ov, 1'b0};
  endfunction

  state_t             state_q;
  shmode_t            mode_q;
  logic [XLEN-1:0]    work_q;
  logic [SW:0]        rem_q;
  logic [RADDR_W-1:0] sh_rd_q;

  logic               v_q, wb_q, br_q;
  logic [XLEN-1:0]    result_q;
  logic [RADDR_W-1:0] rd_q;
  logic [5:0]         flags_q;

  logic [XLEN-1:0] op_a, op_b, b_eff;
  logic [XLEN:0]   sum_c;
  logic [SW-1:0]   shamt;
  logic            hold, stall_c, accept;

  assign op_a    = bus.rd_value_i;
  assign op_b    = bus.immf_i ? bus.imm_value_i : bus.rs_value_i;
  assign shamt   = op_b[SW-1:0];
  assign b_eff   = bus.opcode_i[0] ? ~op_b : op_b;
  assign sum_c   = {1'b0, op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, bus.opcode_i[0]};
  assign hold    = v_q && bus.stall_i;
  assign stall_c = (state_q == SHIFT) || hold;
  assign accept  = bus.v_i && !stall_c;

  logic unused_opcode_bit;
  assign unused_opcode_bit = bus.opcode_i[6];

  // Decode of an instruction presented in IDLE, class priority br > st > ld > shift > logic > inte
  logic [XLEN-1:0] res_c;
  logic            wb_c, brt_c, setf_c, cy_c, ov_c, long_c;

  always_comb begin
    res_c  = '0;
    wb_c   = 1'b0;
    brt_c  = 1'b0;
    setf_c = 1'b0;
    cy_c   = 1'b0;
    ov_c   = 1'b0;
    long_c = 1'b0;
    if (bus.ctrl_br_i) begin
      res_c = op_b;
      brt_c = (bus.opcode_i[5:0] == '0) || |(bus.opcode_i[5:0] & flags_q);
    end else if (bus.ctrl_st_i) begin
      res_c = op_a + bus.imm_value_i;
    end else if (bus.ctrl_ld_i) begin
      res_c = op_a + bus.imm_value_i;
      wb_c  = 1'b1;
    end else if (bus.ctrl_shift_i) begin
      res_c  = op_a;
      wb_c   = 1'b1;
      setf_c = 1'b1;
      long_c = (shamt != '0);
    end else if (bus.ctrl_logic_i) begin
      case (bus.opcode_i[1:0])
        2'b00:   res_c = op_a & op_b;
        2'b01:   res_c = op_a | op_b;
        2'b10:   res_c = op_a ^ op_b;
        default: res_c = ~op_a;
      endcase
      wb_c   = 1'b1;
      setf_c = 1'b1;
    end else if (bus.ctrl_inte_i) begin
      res_c  = sum_c[XLEN-1:0];
      cy_c   = sum_c[XLEN];
      ov_c   = (op_a[XLEN-1] == b_eff[XLEN-1]) && (sum_c[XLEN-1] != op_a[XLEN-1]);
      wb_c   = 1'b1;
      setf_c = 1'b1;
    end
  end

  logic            last_c;
  logic [SW:0]     step_c;
  logic [XLEN-1:0] shifted_c;

  assign last_c    = (rem_q <= STEP);
  assign step_c    = last_c ? rem_q : STEP;
  assign shifted_c = shift_by(work_q, mode_q, step_c);

  // One output-load path shared by single-cycle ops and the final shift step
  logic               load_c, ld_wb, ld_br, ld_setf, ld_cy, ld_ov;
  logic [XLEN-1:0]    ld_res;
  logic [RADDR_W-1:0] ld_rd;

  always_comb begin
    if (state_q == IDLE) begin
      load_c  = accept && !long_c;
      ld_res  = res_c;
      ld_rd   = bus.rd_addr_i;
      ld_wb   = wb_c;
      ld_br   = brt_c;
      ld_setf = setf_c;
      ld_cy   = cy_c;
      ld_ov   = ov_c;
    end else begin
      load_c  = last_c && !hold;
      ld_res  = shifted_c;
      ld_rd   = sh_rd_q;
      ld_wb   = 1'b1;
      ld_br   = 1'b0;
      ld_setf = 1'b1;
      ld_cy   = 1'b0;
      ld_ov   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mode_q   <= SH_SLL;
      work_q   <= '0;
      rem_q    <= '0;
      sh_rd_q  <= '0;
      v_q      <= 1'b0;
      wb_q     <= 1'b0;
      br_q     <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && long_c) begin
            state_q <= SHIFT;
            mode_q  <= shmode_t'(bus.opcode_i[1:0]);
            work_q  <= op_a;
            rem_q   <= {1'b0, shamt};
            sh_rd_q <= bus.rd_addr_i;
          end
        end
        default: begin
          // The final step stalls in place while the previous result is still blocked
          if (!(last_c && hold)) begin
            work_q <= shifted_c;
            rem_q  <= rem_q - step_c;
            if (last_c) state_q <= IDLE;
          end
        end
      endcase

      if (load_c) begin
        v_q      <= 1'b1;
        result_q <= ld_res;
        rd_q     <= ld_rd;
        wb_q     <= ld_wb;
        br_q     <= ld_br;
        if (ld_setf) flags_q <= mk_flags(ld_res, ld_cy, ld_ov);
      end else if (v_q && !bus.stall_i) begin
        v_q <= 1'b0;
      end
    end
  end

  assign bus.stall_o     = stall_c;
  assign bus.v_o         = v_q;
  assign bus.result_o    = result_q;
  assign bus.rd_addr_o   = rd_q;
  assign bus.wb_en_o     = wb_q;
  assign bus.branch_en_o = br_q;
  assign bus.flags_o     = flags_q;
endmodule

// File: tb/tb_ex_pipe.sv
// Directed bench for ex_pipe: hand-computed vectors for arithmetic, flags,
// branches, multi-cycle shifts, back-pressure and mid-shift reset.
module tb_ex_pipe;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 4;

  localparam int C_NOP = 0, C_INTE = 1, C_LOGIC = 2, C_SHIFT = 3, C_LD = 4, C_ST = 5, C_BR = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_pipe_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

  ex_pipe #(.XLEN(XLEN), .RADDR_W(RADDR_W), .SHIFT_STEP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int cls, input logic [6:0] opc, input logic [31:0] a,
                       input logic [31:0] rs, input logic [31:0] imm,
                       input logic immf, input logic [3:0] rd);
    bus.v_i          = 1'b1;
    bus.opcode_i     = opc;
    bus.rd_value_i   = a;
    bus.rs_value_i   = rs;
    bus.imm_value_i  = imm;
    bus.immf_i       = immf;
    bus.rd_addr_i    = rd;
    bus.ctrl_inte_i  = (cls == C_INTE);
    bus.ctrl_logic_i = (cls == C_LOGIC);
    bus.ctrl_shift_i = (cls == C_SHIFT);
    bus.ctrl_ld_i    = (cls == C_LD);
    bus.ctrl_st_i    = (cls == C_ST);
    bus.ctrl_br_i    = (cls == C_BR);
  endtask

  task automatic issue(input int cls, input logic [6:0] opc, input logic [31:0] a,
                       input logic [31:0] rs, input logic [31:0] imm,
                       input logic immf, input logic [3:0] rd);
    drive(cls, opc, a, rs, imm, immf, rd);
    tick();
    bus.v_i = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] res, input logic [5:0] flags,
                           input logic wb, input logic br);
    check({tag, ".v_o"},    64'(bus.v_o), 64'(1'b1));
    check({tag, ".result"}, 64'(bus.result_o), 64'(res));
    check({tag, ".flags"},  64'(bus.flags_o), 64'(flags));
    check({tag, ".wb_en"},  64'(bus.wb_en_o), 64'(wb));
    check({tag, ".br_en"},  64'(bus.branch_en_o), 64'(br));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".v_o"},     64'(bus.v_o), 64'(1'b0));
    check({tag, ".result"},  64'(bus.result_o), 64'(0));
    check({tag, ".rd_addr"}, 64'(bus.rd_addr_o), 64'(0));
    check({tag, ".wb_en"},   64'(bus.wb_en_o), 64'(1'b0));
    check({tag, ".br_en"},   64'(bus.branch_en_o), 64'(1'b0));
    check({tag, ".flags"},   64'(bus.flags_o), 64'(0));
    check({tag, ".stall_o"}, 64'(bus.stall_o), 64'(1'b0));
  endtask

  initial begin
    drive(C_NOP, 7'd0, '0, '0, '0, 1'b0, 4'd0);
    bus.v_i     = 1'b0;
    bus.stall_i = 1'b0;
    #1;
    check_reset("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // ADD 0x7FFFFFFF + 1: signed overflow into the sign bit
    issue(C_INTE, 7'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 4'd3);
    check_out("add", 32'h8000_0000, 6'b001010, 1'b1, 1'b0);
    check("add.rd_addr", 64'(bus.rd_addr_o), 64'(3));

    issue(C_INTE, 7'd1, 32'd5, 32'd0, 32'd5, 1'b1, 4'd4);
    check_out("sub", 32'h0, 6'b100100, 1'b1, 1'b0);

    issue(C_BR, 7'b0100000, 32'h0, 32'h0, 32'h40, 1'b1, 4'd0);
    check_out("br_zero", 32'h40, 6'b100100, 1'b0, 1'b1);

    issue(C_BR, 7'b0010000, 32'h0, 32'h0, 32'h80, 1'b1, 4'd0);
    check_out("br_pos", 32'h80, 6'b100100, 1'b0, 1'b0);

    // SRA by 20 with 8-bit steps: three cycles of stall_o
    drive(C_SHIFT, 7'd2, 32'h8000_0000, 32'h0, 32'd20, 1'b1, 4'd5);
    #1 check("sra.accept_stall", 64'(bus.stall_o), 64'(1'b0));
    tick();
    bus.v_i = 1'b0;
    check("sra.stall1", 64'(bus.stall_o), 64'(1'b1));
    check("sra.v_o_drop", 64'(bus.v_o), 64'(1'b0));
    tick();
    check("sra.stall2", 64'(bus.stall_o), 64'(1'b1));
    tick();
    check("sra.stall3", 64'(bus.stall_o), 64'(1'b1));
    tick();
    check("sra.stall_done", 64'(bus.stall_o), 64'(1'b0));
    check_out("sra", 32'hFFFF_F800, 6'b001000, 1'b1, 1'b0);
    check("sra.rd_addr", 64'(bus.rd_addr_o), 64'(5));

    // Back-pressure with a pending upstream ADD
    bus.stall_i = 1'b1;
    drive(C_INTE, 7'd0, 32'd1, 32'd2, 32'd0, 1'b0, 4'd6);
    #1 check("hold.stall_o", 64'(bus.stall_o), 64'(1'b1));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold.result", 64'(bus.result_o), 64'(32'hFFFF_F800));
      check("hold.flags", 64'(bus.flags_o), 64'(6'b001000));
      check("hold.v_o", 64'(bus.v_o), 64'(1'b1));
      check("hold.stall_o", 64'(bus.stall_o), 64'(1'b1));
    end
    bus.stall_i = 1'b0;
    #1 check("release.stall_o", 64'(bus.stall_o), 64'(1'b0));
    tick();
    bus.v_i = 1'b0;
    check_out("add_after_hold", 32'd3, 6'b010000, 1'b1, 1'b0);
    check("add_after_hold.rd_addr", 64'(bus.rd_addr_o), 64'(6));

    issue(C_ST, 7'd0, 32'h100, 32'h0, 32'h20, 1'b0, 4'd7);
    check_out("st", 32'h120, 6'b010000, 1'b0, 1'b0);

    issue(C_LD, 7'd0, 32'h200, 32'h0, 32'h8, 1'b0, 4'd8);
    check_out("ld", 32'h208, 6'b010000, 1'b1, 1'b0);

    issue(C_LOGIC, 7'd3, 32'h0, 32'h0, 32'h0, 1'b0, 4'd9);
    check_out("not", 32'hFFFF_FFFF, 6'b001000, 1'b1, 1'b0);

    issue(C_LOGIC, 7'd2, 32'hF0F0_00FF, 32'h0F0F_00FF, 32'h0, 1'b0, 4'd9);
    check_out("xor", 32'hFFFF_0000, 6'b001000, 1'b1, 1'b0);

    // Zero shift amount completes in one cycle with result = A
    issue(C_SHIFT, 7'd0, 32'h1234, 32'h0, 32'h0, 1'b1, 4'd10);
    check_out("sll0", 32'h1234, 6'b010000, 1'b1, 1'b0);
    check("sll0.stall_o", 64'(bus.stall_o), 64'(1'b0));

    issue(C_SHIFT, 7'd3, 32'h8000_0001, 32'h0, 32'd4, 1'b1, 4'd11);
    check("rol.stall", 64'(bus.stall_o), 64'(1'b1));
    check("rol.v_o_drop", 64'(bus.v_o), 64'(1'b0));
    tick();
    check_out("rol", 32'h0000_0018, 6'b010000, 1'b1, 1'b0);

    issue(C_NOP, 7'd0, 32'h55, 32'h66, 32'h77, 1'b0, 4'd12);
    check_out("nop", 32'h0, 6'b010000, 1'b0, 1'b0);

    // Reset in the middle of a 31-position shift
    issue(C_SHIFT, 7'd0, 32'h1, 32'h0, 32'd31, 1'b1, 4'd13);
    check("sll31.stall", 64'(bus.stall_o), 64'(1'b1));
    tick();
    rst = 1'b0;
    #1 check_reset("mid_shift_reset");
    #2 rst = 1'b1;
    issue(C_INTE, 7'd0, 32'd2, 32'd3, 32'd0, 1'b0, 4'd14);
    check_out("add_after_reset", 32'd5, 6'b010000, 1'b1, 1'b0);
    check("add_after_reset.rd_addr", 64'(bus.rd_addr_o), 64'(14));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_pipe.md
# ex_pipe

Parametrised execute stage of the venus pipeline, sitting between decode/register-read and memory/write-back. It computes integer add/sub, logic, and shift results, plus load/store addresses and branch targets. It maintains a six-bit condition-flag register, evaluates conditional branches against it, and uses an iterative multi-cycle shifter. Valid/stall handshakes are provided on both sides, so the stage can hold results under downstream back-pressure.

## Interface
Parameters:
- XLEN, 32, datapath width. Must be a power of two, at least 8.
- RADDR_W, 4, destination register address width.
- SHIFT_STEP, 8, maximum bit positions the shifter advances per cycle. Must be a power of two, 1..XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- v_i  in  1  upstream instruction valid.
- stall_o  out  1  upstream must hold its inputs; the instruction is accepted only when v_i=1 and stall_o=0.
- rd_value_i, rs_value_i, imm_value_i  in  XLEN  operands.
- rd_addr_i  in  RADDR_W  destination register.
- opcode_i  in  7  operation sub-code.
- ctrl_inte_i, ctrl_logic_i, ctrl_shift_i, ctrl_ld_i, ctrl_st_i, ctrl_br_i  in  1  class select.
- immf_i  in  1  second operand B = imm_value_i when 1, else rs_value_i.
- v_o  out  1  output registers hold a valid result.
- stall_i  in  1  downstream cannot consume this cycle.
- result_o  out  XLEN  registered result.
- rd_addr_o  out  RADDR_W  registered destination.
- wb_en_o  out  1  registered write-back enable.
- branch_en_o  out  1  registered branch-taken.
- flags_o  out  6  flag register: [5] zero, [4] pos, [3] neg, [2] carry, [1] overflow, [0] reserved (always 0).

## Operation
Operands: A = rd_value_i, B = selected by immf_i. Class priority when several ctrl bits are set: br > st > ld > shift > logic > inte. No ctrl bit set is a nop.

Operations by class:
- inte: opcode_i[0]=0 gives A+B; =1 gives A-B, computed as A + ~B + 1.
  - carry = bit XLEN of the sum.
  - overflow = signed overflow.
- logic: opcode_i[1:0] selects 00 AND, 01 OR, 10 XOR, 11 NOT A.
  - carry = 0, overflow = 0.
- shift: shamt = B[log2(XLEN)-1:0]. opcode_i[1:0] selects 00 SLL, 01 SRL, 10 SRA, 11 rotate-left.
  - carry = 0, overflow = 0.
- ld/st: result = A + imm_value_i (address). Flags are not updated.
- br: result = B (target). Flags are not updated.
  - mask = opcode_i[5:0].
  - branch taken = (mask==0) or |(mask & flags_q).
- nop: result 0, wb_en 0, flags unchanged.

Common output fields:
- zero = (result==0); neg = result[XLEN-1]; pos = !zero && !neg.
- Flags update only for inte, logic, and shift, and only at the edge the result enters the output registers.
- wb_en = !(br or st or nop). branch_en = 1 only for a taken branch.

State machine:
- IDLE: on acceptance, every op except shift with shamt>0 loads the output registers (v_o=1) at the same edge and the stage stays in IDLE.
- A shift with shamt>0 instead latches operand, mode, rd_addr, and remaining=shamt, then moves to SHIFT.
- SHIFT: each edge shifts the working value by min(remaining, SHIFT_STEP) and decrements remaining.
  - The step that brings remaining to 0 also loads the output registers and flags, then returns to IDLE.
  - While v_o && stall_i, that final step waits: the working value is unchanged and the stage stays in SHIFT.

Output handshake:
- stall_o = (state==SHIFT) || (v_o && stall_i). This is combinational.
- While v_o && stall_i, all output registers and flags hold.
- When v_o && !stall_i and no new result loads that edge, v_o drops to 0.

Flag visibility: a branch sees the flags of every instruction accepted before it, with no forwarding hazard. Flag-setting results load at or before the edge that frees the stage.

## Timing
- Reset values (async, rst low): v_o=0, result_o=0, rd_addr_o=0, wb_en_o=0, branch_en_o=0, flags_o=0, state=IDLE, stall_o=0.
- Single-cycle ops: latency 1. Accepted at edge E0, visible on the outputs after E0. Throughput is 1 per cycle when stall_i=0.
- Shift: outputs are valid after edge E0+k, where k = ceil(shamt/SHIFT_STEP), plus any cycles blocked by stall_i. stall_o=1 for the k cycles after acceptance.
- shamt=0: treated as single-cycle; result = A, k=0.
- Reset asserted mid-shift aborts the operation. The partial result is discarded and nothing is written.
- Back-to-back: a new instruction is accepted the same edge the previous result is consumed (v_o=1, stall_i=0, stall_o=0).

## Test plan
- Reset, then ADD with A=0x7FFFFFFF, B=1, no stall -> next cycle: result_o=0x80000000, flags_o=6'b001010 (neg, overflow), wb_en_o=1, v_o=1.
- SUB with A=5, B=5 -> result_o=0, flags_o=6'b100100 (zero, carry).
  - Then br with mask=6'b100000 -> branch_en_o=1, wb_en_o=0.
  - Then br with mask=6'b010000 -> branch_en_o=0.
- SRA with A=0x80000000, shamt=20, SHIFT_STEP=8 -> stall_o high for 3 cycles; result_o=0xFFFFF800 after edge E0+3; flags_o=6'b001000.
- Hold stall_i=1 for 4 cycles while v_o=1 and v_i=1 -> result_o, flags_o, and v_o stable; stall_o=1; upstream not accepted until stall_i falls.
- ST with A=0x100, imm=0x20 -> result_o=0x120, wb_en_o=0, flags unchanged.
  - NOT with A=0 -> result_o=0xFFFFFFFF, neg flag set.
- Assert rst low during a shift of shamt=31 -> all outputs zero immediately, stall_o=0. The first instruction accepted after reset is processed normally.
